// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset defaults, opcode constants and
// small PC arithmetic helpers used by the fetch stage.
package mips_pkg;

   localparam int unsigned XLEN = 32;

   // Default fetch address after reset and default bubble instruction.
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Primary opcode field values decoded by the control unit.
   localparam logic [5:0] R_TYPE = 6'h00;
   localparam logic [5:0] ADDI   = 6'h08;
   localparam logic [5:0] ORI    = 6'h0D;
   localparam logic [5:0] BEQ    = 6'h04;
   localparam logic [5:0] BNE    = 6'h05;

   // Instruction words are 4 bytes; fetch addresses are always word aligned.
   localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

   // Force a byte address onto a word boundary by clearing the low two bits.
   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   // Sequential successor of a PC; wraps modulo 2^32 with no overflow flag.
   function automatic logic [XLEN-1:0] pcIncrement(input logic [XLEN-1:0] pc);
      return pc + INSTR_BYTES;
   endfunction

   // Primary opcode field of an instruction word.
   function automatic logic [5:0] opcodeOf(input logic [XLEN-1:0] instr);
      return instr[31:26];
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register: synchronous reset, load of an (aligned) target,
// and enabled sequential increment. Load takes priority over enable so a
// redirect still lands while the pipeline is stalled.
module pc_register
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [31:0] loadValue,
   output logic [31:0] pc
);

   logic [31:0] pcNext;

   // Select the next PC value: load target, sequential successor or hold.
   always_comb begin
      pcNext = pc;
      if (load) begin
         pcNext = alignPc(loadValue);
      end else if (enable) begin
         pcNext = pcIncrement(pc);
      end
   end

   // PC state register with synchronous reset to the configured fetch start.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= alignPc(RESET_PC);
      end else begin
         pc <= pcNext;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC (via pc_register), presents it to a
// combinational-read instruction memory and captures the returned word into
// the IF/ID pipeline register. Priority: reset > redirect > stall > advance.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifid_instruction,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic [5:0]  ifid_op
);

   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        pcAdvance;

   // A stall freezes the PC unless a redirect overrides it inside pc_register.
   assign pcAdvance = ~stall;

   pc_register #(
      .RESET_PC(RESET_PC)
   ) pcReg (
      .clk      (clk),
      .reset    (reset),
      .enable   (pcAdvance),
      .load     (redirect),
      .loadValue(redirect_target),
      .pc       (pc)
   );

   // Memory sees the PC register directly; the successor feeds IF/ID.
   always_comb begin
      imem_addr = pc;
      pcPlus4   = pcIncrement(pc);
   end

   // IF/ID pipeline register: capture on advance, bubble on redirect, hold on stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_instruction <= NOP_WORD;
         ifid_pc_plus4    <= '0;
         ifid_valid       <= 1'b0;
      end else if (redirect) begin
         ifid_instruction <= NOP_WORD;
         ifid_pc_plus4    <= '0;
         ifid_valid       <= 1'b0;
      end else if (!stall) begin
         ifid_instruction <= imem_rdata;
         ifid_pc_plus4    <= pcPlus4;
         ifid_valid       <= 1'b1;
      end
   end

   // Opcode field for the control unit follows the registered instruction.
   always_comb begin
      ifid_op = opcodeOf(ifid_instruction);
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations followed by randomized control traffic, all compared every
// cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instruction;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic [5:0]  ifid_op;

   int unsigned nCompared = 0;
   int unsigned nFailed   = 0;

   instruction_fetch #(
      .RESET_PC(RST_PC),
      .NOP_WORD(NOP)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .ifid_instruction(ifid_instruction),
      .ifid_pc_plus4   (ifid_pc_plus4),
      .ifid_valid      (ifid_valid),
      .ifid_op         (ifid_op)
   );

   always #5 clk = ~clk;

   // Instruction ROM: one pinned ADDI word, a scrambled pattern elsewhere.
   function automatic logic [31:0] romWord(input logic [31:0] a);
      if (a == 32'h0040_0000) return 32'h2008_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   always_comb imem_rdata = romWord(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mPc, mInstr, mPlus4;
   logic        mValid;
   bit          mKnown = 0;

   always @(posedge clk) begin
      if (reset) begin
         mPc = RST_PC; mInstr = NOP; mPlus4 = 0; mValid = 0; mKnown = 1;
      end else if (mKnown) begin
         if (redirect) begin
            mPc = (redirect_target / 4) * 4;
            mInstr = NOP; mPlus4 = 0; mValid = 0;
         end else if (!stall) begin
            mInstr = romWord(mPc);
            mPlus4 = 32'((64'(mPc) + 64'd4) % 64'h1_0000_0000);
            mPc    = mPlus4;
            mValid = 1;
         end
      end
   end

   // Single compare process: DUT versus model on every settled cycle.
   always @(negedge clk) begin
      if (mKnown) begin
         check("pc",     imem_addr, mPc);
         check("instr",  ifid_instruction, mInstr);
         check("plus4",  ifid_pc_plus4, mPlus4);
         check("valid",  32'(ifid_valid), 32'(mValid));
         check("op",     32'(ifid_op), mInstr >> 26);
      end
   end

   // Drive one cycle of controls, let the edge happen, return at the next negedge.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
      reset = r; stall = s; redirect = rd; redirect_target = t;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1; stall = 0; redirect = 0; redirect_target = 0;
      // Reset held for two cycles.
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_addr",  imem_addr, 32'h0040_0000);
      check("rst_valid", 32'(ifid_valid), 32'd0);
      check("rst_op",    32'(ifid_op), 32'd0);

      // First fetch: ADDI at reset PC.
      step(0, 0, 0, 0);
      check("f1_valid", 32'(ifid_valid), 32'd1);
      check("f1_plus4", ifid_pc_plus4, 32'h0040_0004);
      check("f1_instr", ifid_instruction, 32'h2008_0005);
      check("f1_op",    32'(ifid_op), 32'h08);
      check("f1_addr",  imem_addr, 32'h0040_0004);

      // Advance to 0x00400008 then stall three cycles.
      step(0, 0, 0, 0);
      check("pre_stall_addr", imem_addr, 32'h0040_0008);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("stall_addr",  imem_addr, 32'h0040_0008);
         check("stall_plus4", ifid_pc_plus4, 32'h0040_0008);
         check("stall_valid", 32'(ifid_valid), 32'd1);
      end
      step(0, 0, 0, 0);
      check("unstall_addr",  imem_addr, 32'h0040_000C);
      check("unstall_plus4", ifid_pc_plus4, 32'h0040_000C);

      // Redirect squashes.
      step(0, 0, 1, 32'h0040_0020);
      check("redir_addr",  imem_addr, 32'h0040_0020);
      check("redir_valid", 32'(ifid_valid), 32'd0);
      check("redir_op",    32'(ifid_op), 32'd0);

      // Redirect while stalled, misaligned target.
      step(0, 1, 1, 32'h0040_0103);
      check("rs_addr",  imem_addr, 32'h0040_0100);
      check("rs_valid", 32'(ifid_valid), 32'd0);

      // Wrap around the top of the address space.
      step(0, 0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      check("wrap_addr",  imem_addr, 32'h0000_0000);
      check("wrap_plus4", ifid_pc_plus4, 32'h0000_0000);
      check("wrap_valid", 32'(ifid_valid), 32'd1);

      // Back-to-back redirects each take effect.
      step(0, 0, 1, 32'h0000_1000);
      check("b2b1_addr", imem_addr, 32'h0000_1000);
      step(0, 0, 1, 32'h0000_2002);
      check("b2b2_addr", imem_addr, 32'h0000_2000);

      // Reset overrides stall and redirect together.
      step(1, 1, 1, 32'h1234_5678);
      check("rovr_addr",  imem_addr, 32'h0040_0000);
      check("rovr_valid", 32'(ifid_valid), 32'd0);
      step(0, 0, 0, 0);
      check("rovr_fetch", ifid_instruction, 32'h2008_0005);

      // Randomized control traffic.
      for (int i = 0; i < 600; i++) begin
         logic        r, s, rd;
         logic [31:0] t;
         r  = ($urandom_range(0, 39) == 0);
         s  = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 5) == 0);
         t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         step(r, s, rd, t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, the bubble instruction inserted on squash.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port stall, input, 1, which holds the PC and the IF/ID register.
REQ-006 SHALL have port redirect, input, 1, which signals a taken branch or jump from a later stage.
REQ-007 SHALL have port redirect_target, input, 32, the next fetch address when redirect=1.
REQ-008 SHALL have port imem_addr, output, 32, the current PC to instruction memory (combinational-read ROM).
REQ-009 SHALL have port imem_rdata, input, 32, the instruction word at imem_addr, valid in the same cycle.
REQ-010 SHALL have port ifid_instruction, output, 32, the registered instruction for decode.
REQ-011 SHALL have port ifid_pc_plus4, output, 32, the registered PC+4 for branch and jump target computation.
REQ-012 SHALL have port ifid_valid, output, 1, which is 1 when ifid_instruction holds a real fetched instruction.
REQ-013 SHALL have port ifid_op, output, 6, equal to ifid_instruction[31:26], which feeds the control unit OP input.

Function
REQ-014 SHALL drive imem_addr directly from the PC register, with no extra cycle.
REQ-015 SHALL use one cycle of latency: the word fetched at PC in cycle n appears on ifid_* after edge n+1.
REQ-016 SHALL, on a normal edge (no reset, redirect or stall), update as: PC <= PC+4, ifid_instruction <= imem_rdata, ifid_pc_plus4 <= PC+4, ifid_valid <= 1.
REQ-017 SHALL, on a stall edge, hold the PC, ifid_instruction, ifid_pc_plus4 and ifid_valid unchanged.
REQ-018 SHALL, on a redirect edge, set PC <= {redirect_target[31:2],2'b00}, ifid_instruction <= NOP_WORD, ifid_pc_plus4 <= 0 and ifid_valid <= 0, squashing the wrong-path fetch.
REQ-019 SHALL apply the priority reset > redirect > stall > normal; redirect with stall asserted SHALL still redirect and squash.
REQ-020 SHALL compute PC+4 as a 32-bit sum with modulo wrap: PC 32'hFFFF_FFFC yields next PC 32'h0000_0000, with no error flag.
REQ-021 SHALL keep PC[1:0] at 2'b00 at all times; misaligned targets are silently aligned.
REQ-022 SHALL use no FSM beyond the PC register and the IF/ID valid bit; back-to-back redirects on consecutive edges SHALL each take effect.
REQ-023 SHALL combinationally track ifid_op from ifid_instruction, so a bubble gives ifid_op=6'h00.

Reset
REQ-024 SHALL, on a reset edge, set PC <= RESET_PC, ifid_instruction <= NOP_WORD, ifid_pc_plus4 <= 0 and ifid_valid <= 0.
REQ-025 SHALL, when reset is asserted mid-stall or mid-redirect, override both; the first fetch after release SHALL be at RESET_PC.
REQ-026 SHALL have no asynchronous reset path.

Structure
REQ-027 SHALL place RESET_PC default, NOP_WORD and the opcode constants (R_TYPE 6'h00, ADDI 6'h08, ORI 6'h0D, BEQ 6'h04, BNE 6'h05) in the shared package mips_pkg.
REQ-028 SHALL instantiate one sub-module, pc_register (32-bit, sync reset to RESET_PC, enable, load), for the PC; the IF/ID register stays inline.

Verification
REQ-029 SHALL cover reset: reset high for 2 cycles then low; imem_addr=32'h0040_0000, and ifid_valid=0 until the first edge, then 1 with ifid_pc_plus4=32'h0040_0004.
REQ-030 SHALL cover sequential fetch: ROM[0x00400000]=32'h2008_0005 (ADDI); after one edge ifid_op=6'h08 and ifid_instruction=32'h2008_0005.
REQ-031 SHALL cover stall: stall=1 for 3 cycles at PC 32'h0040_0008; imem_addr and all ifid_* stay constant, and on release PC advances to 32'h0040_000C.
REQ-032 SHALL cover redirect: redirect=1, target=32'h0040_0020; the next cycle gives imem_addr=32'h0040_0020, ifid_valid=0 and ifid_op=6'h00.
REQ-033 SHALL cover simultaneous redirect with stall: stall=1, redirect=1, target=32'h0040_0103; the result is PC=32'h0040_0100 and ifid_valid=0.
REQ-034 SHALL cover wrap: force PC to 32'hFFFF_FFFC via a redirect; after one normal edge imem_addr=32'h0000_0000 and ifid_pc_plus4=32'h0000_0000.
